// File: rtl/sprite_pixel_compositor_pkg.sv
// Shared constants and encodings for the sprite pixel compositor.
//   TILE_DEF / TILE_LOG2_DEF : default tile/sprite edge and its log2
//   ANIM_DIV_DEF             : default frame_start pulses per animation toggle
//   *_RGB_DEF                : default 12-bit {r,g,b} colours
//   tile_t                   : map entry encoding
//   dir_t                    : sprite direction encoding
package sprite_pixel_compositor_pkg;

  localparam int TILE_DEF      = 16;
  localparam int TILE_LOG2_DEF = 4;
  localparam int ANIM_DIV_DEF  = 8;

  localparam logic [11:0] BG_RGB_DEF     = 12'h000;
  localparam logic [11:0] WALL_RGB_DEF   = 12'h00F;
  localparam logic [11:0] DOT_RGB_DEF    = 12'hFB9;
  localparam logic [11:0] PLAYER_RGB_DEF = 12'hFF0;
  localparam logic [11:0] SCLERA_RGB_DEF = 12'hFFF;
  localparam logic [11:0] EYE_RGB_DEF    = 12'h00F;

  typedef enum logic [1:0] {
    TT_EMPTY   = 2'd0,
    TT_WALL    = 2'd1,
    TT_DOT     = 2'd2,
    TT_BIG_DOT = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

endpackage

// File: rtl/sprite_pixel_compositor_if.sv
// Pixel request / colour result bundle between the VGA timing side and
// the compositor.
//   pix_valid, pix_x, pix_y, tile_type : pixel request (master -> slave)
//   rgb_valid, rgb                     : composed colour (slave -> master)
interface sprite_pixel_compositor_if;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [1:0]  tile_type;
  logic        rgb_valid;
  logic [11:0] rgb;

  modport master (output pix_valid, pix_x, pix_y, tile_type,
                  input  rgb_valid, rgb);
  modport slave  (input  pix_valid, pix_x, pix_y, tile_type,
                  output rgb_valid, rgb);
endinterface

// File: rtl/sprite_pixel_compositor_hit.sv
// sprite_hit_index: decides whether a screen pixel falls inside a sprite
// and returns the row-major bit index into that sprite's TILE x TILE mask.
//   pix_x/pix_y : screen pixel
//   org_x/org_y : sprite top-left
//   dir         : sprite direction (used only when ORIENT=1)
//   hit         : pixel lies inside the sprite
//   idx         : mask bit index, row*TILE+col
module sprite_hit_index
  import sprite_pixel_compositor_pkg::*;
#(
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter bit ORIENT    = 1'b1
) (
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic [9:0]             org_x,
  input  logic [9:0]             org_y,
  input  logic [1:0]             dir,
  output logic                   hit,
  output logic [2*TILE_LOG2-1:0] idx
);
  localparam logic [10:0] TILE_W = 11'(1 << TILE_LOG2);

  logic [10:0]          dx, dy;
  logic [TILE_LOG2-1:0] lx, ly, row, col;

  // Pixels left of / above the origin wrap to >= 1024 and so miss.
  assign dx  = {1'b0, pix_x} - {1'b0, org_x};
  assign dy  = {1'b0, pix_y} - {1'b0, org_y};
  assign hit = (dx < TILE_W) && (dy < TILE_W);
  assign lx  = dx[TILE_LOG2-1:0];
  assign ly  = dy[TILE_LOG2-1:0];

  // TILE is a power of two, so TILE-1-v is simply ~v.
  always_comb begin
    row = ly;
    col = lx;
    if (ORIENT) begin
      case (dir)
        DIR_LEFT:  col = ~lx;
        DIR_UP:    begin row = lx; col = ~ly; end
        DIR_DOWN:  begin row = lx; col = ly;  end
        default:   ;
      endcase
    end
  end

  assign idx = {row, col};
endmodule

// File: rtl/sprite_pixel_compositor.sv
// sprite_pixel_compositor: 3-stage pixel pipeline composing the final
// 12-bit colour from tile map, dot masks, player and ghost sprites.
//   clk, rst_n        : clock, async active-low reset
//   frame_start       : one-cycle pulse per frame, drives animation toggle
//   pif (slave)       : pixel request in, colour result out (latency 3)
//   player_*/ghost_*  : sprite origins, directions, ghost colour
//   *_mask*           : TILE*TILE row-major 1-bit masks
//   anim_sel          : 0 selects f1 sprite masks, 1 selects f2
module sprite_pixel_compositor
  import sprite_pixel_compositor_pkg::*;
#(
  parameter int          TILE       = TILE_DEF,
  parameter int          TILE_LOG2  = TILE_LOG2_DEF,
  parameter int          ANIM_DIV   = ANIM_DIV_DEF,
  parameter logic [11:0] BG_RGB     = BG_RGB_DEF,
  parameter logic [11:0] WALL_RGB   = WALL_RGB_DEF,
  parameter logic [11:0] DOT_RGB    = DOT_RGB_DEF,
  parameter logic [11:0] PLAYER_RGB = PLAYER_RGB_DEF,
  parameter logic [11:0] SCLERA_RGB = SCLERA_RGB_DEF,
  parameter logic [11:0] EYE_RGB    = EYE_RGB_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  sprite_pixel_compositor_if.slave pif,
  input  logic [9:0]             player_x,
  input  logic [9:0]             player_y,
  input  logic [1:0]             player_dir,
  input  logic [9:0]             ghost_x,
  input  logic [9:0]             ghost_y,
  input  logic [1:0]             ghost_dir,
  input  logic [11:0]            ghost_rgb,
  input  logic [TILE*TILE-1:0]   player_mask_f1,
  input  logic [TILE*TILE-1:0]   player_mask_f2,
  input  logic [TILE*TILE-1:0]   ghost_mask_f1,
  input  logic [TILE*TILE-1:0]   ghost_mask_f2,
  input  logic [TILE*TILE-1:0]   dot_mask,
  input  logic [TILE*TILE-1:0]   big_dot_mask,
  input  logic [TILE*TILE-1:0]   sclera_mask_up,
  input  logic [TILE*TILE-1:0]   sclera_mask_down,
  input  logic [TILE*TILE-1:0]   sclera_mask_left,
  input  logic [TILE*TILE-1:0]   sclera_mask_right,
  input  logic [TILE*TILE-1:0]   eye_mask_up,
  input  logic [TILE*TILE-1:0]   eye_mask_down,
  input  logic [TILE*TILE-1:0]   eye_mask_left,
  input  logic [TILE*TILE-1:0]   eye_mask_right,
  output logic                   anim_sel
);
  localparam int IW = 2 * TILE_LOG2;

  // Animation toggle
  logic [7:0] anim_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt <= '0;
      anim_sel <= 1'b0;
    end else if (frame_start) begin
      if (anim_cnt == 8'(ANIM_DIV - 1)) begin
        anim_cnt <= '0;
        anim_sel <= ~anim_sel;
      end else begin
        anim_cnt <= anim_cnt + 8'd1;
      end
    end
  end

  // S1: hit test and mask indices. Player orientation is folded into the
  // index here since player_dir is captured alongside the pixel anyway.
  logic          hit_p, hit_g;
  logic [IW-1:0] idx_p, idx_g;

  sprite_hit_index #(.TILE_LOG2(TILE_LOG2), .ORIENT(1'b1)) u_hit_player (
    .pix_x(pif.pix_x), .pix_y(pif.pix_y), .org_x(player_x), .org_y(player_y),
    .dir(player_dir), .hit(hit_p), .idx(idx_p)
  );

  sprite_hit_index #(.TILE_LOG2(TILE_LOG2), .ORIENT(1'b0)) u_hit_ghost (
    .pix_x(pif.pix_x), .pix_y(pif.pix_y), .org_x(ghost_x), .org_y(ghost_y),
    .dir(ghost_dir), .hit(hit_g), .idx(idx_g)
  );

  logic          v1, hp1, hg1;
  logic [IW-1:0] tidx1, pidx1, gidx1;
  logic [1:0]    tile1, gdir1;
  logic [11:0]   grgb1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      hp1   <= 1'b0;
      hg1   <= 1'b0;
      tidx1 <= '0;
      pidx1 <= '0;
      gidx1 <= '0;
      tile1 <= '0;
      gdir1 <= '0;
      grgb1 <= '0;
    end else begin
      v1    <= pif.pix_valid;
      hp1   <= hit_p;
      hg1   <= hit_g;
      tidx1 <= {pif.pix_y[TILE_LOG2-1:0], pif.pix_x[TILE_LOG2-1:0]};
      pidx1 <= idx_p;
      gidx1 <= idx_g;
      tile1 <= pif.tile_type;
      gdir1 <= ghost_dir;
      grgb1 <= ghost_rgb;
    end
  end

  // S2: mask lookups
  logic [TILE*TILE-1:0] pmask, gmask, smask, emask;

  assign pmask = anim_sel ? player_mask_f2 : player_mask_f1;
  assign gmask = anim_sel ? ghost_mask_f2  : ghost_mask_f1;

  always_comb begin
    smask = sclera_mask_right;
    emask = eye_mask_right;
    case (gdir1)
      DIR_LEFT: begin smask = sclera_mask_left; emask = eye_mask_left; end
      DIR_UP:   begin smask = sclera_mask_up;   emask = eye_mask_up;   end
      DIR_DOWN: begin smask = sclera_mask_down; emask = eye_mask_down; end
      default:  ;
    endcase
  end

  logic        v2, dot2, big2, pb2, gb2, sc2, ey2;
  logic [1:0]  tile2;
  logic [11:0] grgb2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      dot2  <= 1'b0;
      big2  <= 1'b0;
      pb2   <= 1'b0;
      gb2   <= 1'b0;
      sc2   <= 1'b0;
      ey2   <= 1'b0;
      tile2 <= '0;
      grgb2 <= '0;
    end else begin
      v2    <= v1;
      dot2  <= dot_mask[tidx1];
      big2  <= big_dot_mask[tidx1];
      pb2   <= hp1 & pmask[pidx1];
      gb2   <= hg1 & gmask[gidx1];
      sc2   <= hg1 & smask[gidx1];
      ey2   <= hg1 & emask[gidx1];
      tile2 <= tile1;
      grgb2 <= grgb1;
    end
  end

  // S3: priority compose
  logic [11:0] color;

  always_comb begin
    color = BG_RGB;
    if (ey2)                            color = EYE_RGB;
    else if (sc2)                       color = SCLERA_RGB;
    else if (gb2)                       color = grgb2;
    else if (pb2)                       color = PLAYER_RGB;
    else if (tile2 == TT_BIG_DOT && big2) color = DOT_RGB;
    else if (tile2 == TT_DOT && dot2)   color = DOT_RGB;
    else if (tile2 == TT_WALL)          color = WALL_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pif.rgb_valid <= 1'b0;
      pif.rgb       <= '0;
    end else begin
      pif.rgb_valid <= v2;
      if (v2) pif.rgb <= color;
    end
  end
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Directed bench for sprite_pixel_compositor: reset, animation toggle,
// latency, tile/dot colours, player orientation, ghost priority, offset
// wrap, streaming order and mid-stream reset.
module tb_sprite_pixel_compositor;
  import sprite_pixel_compositor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start;
  logic [9:0] player_x, player_y, ghost_x, ghost_y;
  logic [1:0] player_dir, ghost_dir;
  logic [11:0] ghost_rgb;
  logic [255:0] player_mask_f1, player_mask_f2, ghost_mask_f1, ghost_mask_f2;
  logic [255:0] dot_mask, big_dot_mask;
  logic [255:0] sclera_mask_up, sclera_mask_down, sclera_mask_left, sclera_mask_right;
  logic [255:0] eye_mask_up, eye_mask_down, eye_mask_left, eye_mask_right;
  logic anim_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_pixel_compositor_if pif ();

  sprite_pixel_compositor dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pif(pif.slave),
    .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_dir(ghost_dir),
    .ghost_rgb(ghost_rgb),
    .player_mask_f1(player_mask_f1), .player_mask_f2(player_mask_f2),
    .ghost_mask_f1(ghost_mask_f1), .ghost_mask_f2(ghost_mask_f2),
    .dot_mask(dot_mask), .big_dot_mask(big_dot_mask),
    .sclera_mask_up(sclera_mask_up), .sclera_mask_down(sclera_mask_down),
    .sclera_mask_left(sclera_mask_left), .sclera_mask_right(sclera_mask_right),
    .eye_mask_up(eye_mask_up), .eye_mask_down(eye_mask_down),
    .eye_mask_left(eye_mask_left), .eye_mask_right(eye_mask_right),
    .anim_sel(anim_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  // One isolated pixel; output must appear exactly three edges later.
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [1:0] tt, input logic [11:0] exp);
    @(negedge clk);
    pif.pix_valid = 1'b1;
    pif.pix_x = x;
    pif.pix_y = y;
    pif.tile_type = tt;
    @(negedge clk);
    pif.pix_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(pif.rgb_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(pif.rgb_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(pif.rgb_valid), 32'd1);
    chk(tag, 32'(pif.rgb), 32'(exp));
  endtask

  logic [11:0] exp_q[$];
  logic [11:0] last_e;
  int n_out;

  initial begin
    frame_start = 1'b0;
    pif.pix_valid = 1'b0;
    pif.pix_x = '0;
    pif.pix_y = '0;
    pif.tile_type = '0;
    player_x = 10'd512; player_y = 10'd512; player_dir = 2'd0;
    ghost_x = 10'd900;  ghost_y = 10'd900;  ghost_dir = 2'd0;
    ghost_rgb = 12'hF0F;
    player_mask_f1 = '0; player_mask_f2 = '0;
    ghost_mask_f1 = '0;  ghost_mask_f2 = '0;
    dot_mask = '0; big_dot_mask = '0;
    sclera_mask_up = '0; sclera_mask_down = '0; sclera_mask_left = '0; sclera_mask_right = '0;
    eye_mask_up = '0; eye_mask_down = '0; eye_mask_left = '0; eye_mask_right = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rgb_valid", 32'(pif.rgb_valid), 32'd0);
    chk("rst_rgb", 32'(pif.rgb), 32'd0);
    chk("rst_anim_sel", 32'(anim_sel), 32'd0);

    // Animation toggle
    frame_pulses(7);
    chk("anim_after7", 32'(anim_sel), 32'd0);
    frame_pulses(1);
    chk("anim_after8", 32'(anim_sel), 32'd1);
    repeat (5) @(negedge clk);
    chk("anim_hold_midframe", 32'(anim_sel), 32'd1);
    frame_pulses(8);
    chk("anim_after16", 32'(anim_sel), 32'd0);

    // Tile colours at (5,5): local index 5*16+5 = 85
    dot_mask[85] = 1'b1;
    big_dot_mask[86] = 1'b1;
    pixel("wall_5_5", 10'd5, 10'd5, 2'd1, 12'h00F);
    pixel("dot_5_5", 10'd5, 10'd5, 2'd2, 12'hFB9);
    pixel("bigdot_clear_5_5", 10'd5, 10'd5, 2'd3, 12'h000);
    pixel("bigdot_6_5", 10'd6, 10'd5, 2'd3, 12'hFB9);
    pixel("dot_clear_6_5", 10'd6, 10'd5, 2'd2, 12'h000);
    pixel("empty_5_5", 10'd5, 10'd5, 2'd0, 12'h000);

    // Player at (32,48), f1 all ones except bit 0, f2 empty
    player_x = 10'd32; player_y = 10'd48;
    player_mask_f1 = '1;
    player_mask_f1[0] = 1'b0;
    player_dir = 2'd0;
    pixel("player_r_origin", 10'd32, 10'd48, 2'd1, 12'h00F);
    pixel("player_r_47", 10'd47, 10'd48, 2'd1, 12'hFF0);
    player_dir = 2'd1;
    pixel("player_l_47", 10'd47, 10'd48, 2'd1, 12'h00F);
    player_dir = 2'd0;
    pixel("player_r_33", 10'd33, 10'd48, 2'd1, 12'hFF0);
    player_dir = 2'd2;
    pixel("player_up_32_63", 10'd32, 10'd63, 2'd1, 12'h00F);
    player_dir = 2'd3;
    pixel("player_down_origin", 10'd32, 10'd48, 2'd1, 12'h00F);
    player_dir = 2'd0;
    pixel("player_outside_48", 10'd48, 10'd48, 2'd1, 12'h00F);

    // f2 selected after a toggle: empty f2 shows the tile
    frame_pulses(8);
    chk("anim_toggle_f2", 32'(anim_sel), 32'd1);
    pixel("player_f2_33", 10'd33, 10'd48, 2'd1, 12'h00F);
    frame_pulses(8);
    chk("anim_back_f1", 32'(anim_sel), 32'd0);

    // Offset wrap
    player_x = 10'd1020;
    pixel("wrap_no_hit", 10'd3, 10'd48, 2'd1, 12'h00F);
    player_x = 10'd1008;
    pixel("edge_dx15", 10'd1023, 10'd48, 2'd1, 12'hFF0);

    // Ghost over player at (64,64); pixel (65,65) is bit 17
    player_x = 10'd64; player_y = 10'd64;
    ghost_x = 10'd64;  ghost_y = 10'd64;
    ghost_mask_f1 = '1; ghost_mask_f2 = '1;
    eye_mask_left[17] = 1'b1;
    sclera_mask_right[17] = 1'b1;
    ghost_dir = 2'd1;
    pixel("ghost_eye_left", 10'd65, 10'd65, 2'd0, 12'h00F);
    ghost_dir = 2'd0;
    pixel("ghost_sclera_right", 10'd65, 10'd65, 2'd0, 12'hFFF);
    ghost_dir = 2'd2;
    pixel("ghost_body_up", 10'd65, 10'd65, 2'd0, 12'hF0F);
    ghost_mask_f1 = '0; ghost_mask_f2 = '0;
    pixel("ghost_gone_player", 10'd65, 10'd65, 2'd0, 12'hFF0);

    // 100 back-to-back pixels, sprites out of the way
    player_x = 10'd512; player_y = 10'd512;
    ghost_x = 10'd900;  ghost_y = 10'd900;
    dot_mask = '0;
    for (int k = 0; k < 16; k += 3) dot_mask[80 + k] = 1'b1;
    n_out = 0;
    last_e = '0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [9:0] x;
          logic [1:0] tt;
          logic [11:0] e;
          x = 10'(i);
          tt = 2'(i % 3);
          @(negedge clk);
          pif.pix_valid = 1'b1;
          pif.pix_x = x;
          pif.pix_y = 10'd5;
          pif.tile_type = tt;
          if (tt == 2'd1) e = 12'h00F;
          else if (tt == 2'd2 && (x[3:0] % 3 == 0)) e = 12'hFB9;
          else e = 12'h000;
          exp_q.push_back(e);
          last_e = e;
        end
        @(negedge clk);
        pif.pix_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 115; c++) begin
          @(negedge clk);
          if (pif.rgb_valid) begin
            n_out++;
            if (exp_q.size() > 0) chk("stream", 32'(pif.rgb), 32'(exp_q.pop_front()));
          end
        end
      end
    join
    chk("stream_count", 32'(n_out), 32'd100);
    chk("hold_valid", 32'(pif.rgb_valid), 32'd0);
    chk("hold_rgb", 32'(pif.rgb), 32'(last_e));

    // Reset mid-stream with anim_sel set
    frame_pulses(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pif.pix_valid = 1'b1;
      pif.pix_x = 10'(i);
      pif.pix_y = 10'd5;
      pif.tile_type = 2'd1;
    end
    @(negedge clk);
    chk("pre_reset_valid", 32'(pif.rgb_valid), 32'd1);
    rst_n = 1'b0;
    pif.pix_valid = 1'b0;
    #1;
    chk("reset_async_valid", 32'(pif.rgb_valid), 32'd0);
    chk("reset_anim_sel", 32'(anim_sel), 32'd0);
    @(negedge clk);
    chk("reset_next_valid", 32'(pif.rgb_valid), 32'd0);
    chk("reset_rgb", 32'(pif.rgb), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_flushed", 32'(pif.rgb_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
